// File: rtl/mm_job_arbiter.sv
// rtl/mm_job_arbiter.sv - round-robin arbiter sharing one matrix-multiply unit between NUM_REQ requesters
// Optional WAIT watchdog enabled by defining MM_ARB_TIMEOUT_EN.
module mm_job_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int IDX_W          = 2,
    parameter int SETUP_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic [NUM_REQ-1:0] done_o,
    output logic               mm_start_o,
    input  logic               mm_busy_i,
    input  logic               mm_done_i,
    output logic               arb_busy_o,
    output logic               err_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_START,
        ST_WAIT,
        ST_RELEASE
    } state_t;

    localparam int SC_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = NUM_REQ'(1);

    if (NUM_REQ < 2 || SETUP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mm_job_arbiter: illegal parameter value");
    end

    state_t               state_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [IDX_W-1:0]     grant_idx_q;
    logic [NUM_REQ-1:0]   done_q;
    logic                 start_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [SC_W-1:0]      setup_cnt_q;

    logic                 pick_valid_d;
    logic [IDX_W-1:0]     pick_idx_d;
    logic [IDX_W-1:0]     rr_ptr_d;
    logic [IDX_W-1:0]     cand;
    int                   k;

`ifdef MM_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0]      to_cnt_q;
    logic                 err_q;
`endif

    // Search upward from the round-robin pointer, wrapping at NUM_REQ.
    always_comb begin
        pick_valid_d = 1'b0;
        pick_idx_d   = '0;
        k            = 0;
        cand         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(rr_ptr_q) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            cand = IDX_W'(k);
            if (!pick_valid_d && req_i[cand]) begin
                pick_valid_d = 1'b1;
                pick_idx_d   = cand;
            end
        end
    end

    always_comb begin
        rr_ptr_d = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            done_q      <= '0;
            start_q     <= 1'b0;
            rr_ptr_q    <= '0;
            setup_cnt_q <= '0;
`ifdef MM_ARB_TIMEOUT_EN
            to_cnt_q    <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            done_q  <= '0;
`ifdef MM_ARB_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid_d && !mm_busy_i) begin
                        grant_idx_q <= pick_idx_d;
                        grant_q     <= ONE_HOT_0 << pick_idx_d;
                        setup_cnt_q <= '0;
                        state_q     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (setup_cnt_q == SC_W'(SETUP_CYCLES - 1)) begin
                        start_q <= 1'b1;
                        state_q <= ST_START;
                    end else begin
                        setup_cnt_q <= setup_cnt_q + 1'b1;
                    end
                end
                ST_START: begin
`ifdef MM_ARB_TIMEOUT_EN
                    to_cnt_q <= '0;
`endif
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mm_done_i) begin
                        done_q  <= grant_q;
                        state_q <= ST_RELEASE;
                    end
`ifdef MM_ARB_TIMEOUT_EN
                    else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        done_q  <= grant_q;
                        err_q   <= 1'b1;
                        state_q <= ST_RELEASE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end
                ST_RELEASE: begin
                    rr_ptr_q <= rr_ptr_d;
                    grant_q  <= '0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    grant_q <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_o     = grant_q;
    assign grant_idx_o = grant_idx_q;
    assign done_o      = done_q;
    assign mm_start_o  = start_q;
    assign arb_busy_o  = (state_q != ST_IDLE);
`ifdef MM_ARB_TIMEOUT_EN
    assign err_o       = err_q;
`else
    assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_mm_job_arbiter.sv
// tb/tb_mm_job_arbiter.sv - directed self-checking bench for mm_job_arbiter
// Timeout case runs only when MM_ARB_TIMEOUT_EN is defined.
module tb_mm_job_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_i;
    logic [3:0] grant_o;
    logic [1:0] grant_idx_o;
    logic [3:0] done_o;
    logic       mm_start_o;
    logic       mm_busy_i;
    logic       mm_done_i;
    logic       arb_busy_o;
    logic       err_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mm_job_arbiter #(
        .NUM_REQ       (4),
        .IDX_W         (2),
        .SETUP_CYCLES  (1),
`ifdef MM_ARB_TIMEOUT_EN
        .TIMEOUT_CYCLES(16)
`else
        .TIMEOUT_CYCLES(1024)
`endif
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .grant_o    (grant_o),
        .grant_idx_o(grant_idx_o),
        .done_o     (done_o),
        .mm_start_o (mm_start_o),
        .mm_busy_i  (mm_busy_i),
        .mm_done_i  (mm_done_i),
        .arb_busy_o (arb_busy_o),
        .err_o      (err_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_grant"}, 32'(grant_o), 32'h0);
        check({tag, "_done"}, 32'(done_o), 32'h0);
        check({tag, "_start"}, 32'(mm_start_o), 32'h0);
        check({tag, "_busy"}, 32'(arb_busy_o), 32'h0);
        check({tag, "_err"}, 32'(err_o), 32'h0);
    endtask

    task automatic do_reset(input logic [3:0] req_during);
        rst       = 1'b1;
        req_i     = req_during;
        mm_busy_i = 1'b0;
        mm_done_i = 1'b0;
        tick();
        tick();
        expect_idle("rst");
        check("rst_gidx", 32'(grant_idx_o), 32'h0);
        rst   = 1'b0;
        req_i = 4'b0000;
    endtask

    // Starts with DUT in IDLE and req_i already driven; ends in IDLE.
    task automatic run_job(input int idx, input int lat, input bit drop);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        tick();
        check("job_grant", 32'(grant_o), 32'(oh));
        check("job_gidx", 32'(grant_idx_o), 32'(idx));
        check("job_start_setup", 32'(mm_start_o), 32'h0);
        check("job_busy", 32'(arb_busy_o), 32'h1);
        tick();
        check("job_start", 32'(mm_start_o), 32'h1);
        check("job_grant_start", 32'(grant_o), 32'(oh));
        tick();
        check("job_start_wait", 32'(mm_start_o), 32'h0);
        if (drop) req_i = req_i & ~oh;
        for (int c = 1; c < lat; c++) begin
            tick();
            check("job_done_early", 32'(done_o), 32'h0);
            check("job_grant_wait", 32'(grant_o), 32'(oh));
        end
        mm_done_i = 1'b1;
        tick();
        mm_done_i = 1'b0;
        check("job_done", 32'(done_o), 32'(oh));
        check("job_grant_rel", 32'(grant_o), 32'(oh));
        check("job_err", 32'(err_o), 32'h0);
        tick();
        expect_idle("job_end");
    endtask

    initial begin
        // reset with all requests high, then a single job on requester 2
        do_reset(4'b1111);
        req_i = 4'b0100;
        run_job(2, 10, 1'b0);
        req_i = 4'b0000;

        // stray mm_done_i in IDLE is ignored
        mm_done_i = 1'b1;
        tick();
        mm_done_i = 1'b0;
        expect_idle("stray_done");

        // round-robin with all requests held
        do_reset(4'b0000);
        req_i = 4'b1111;
        run_job(0, 3, 1'b0);
        run_job(1, 3, 1'b0);
        run_job(2, 3, 1'b0);
        run_job(3, 3, 1'b0);
        run_job(0, 3, 1'b0);
        req_i = 4'b0000;

        // request 1 drops during WAIT; job still completes
        do_reset(4'b0000);
        req_i = 4'b0010;
        run_job(1, 4, 1'b1);
        check("commit_req_dropped", 32'(req_i), 32'h0);

        // busy gate holds off the grant
        do_reset(4'b0000);
        req_i     = 4'b0001;
        mm_busy_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("busy_gate_grant", 32'(grant_o), 32'h0);
            check("busy_gate_busy", 32'(arb_busy_o), 32'h0);
        end
        mm_busy_i = 1'b0;
        run_job(0, 2, 1'b0);
        req_i = 4'b0000;

`ifdef MM_ARB_TIMEOUT_EN
        // watchdog: no mm_done_i, release 16 cycles after WAIT entry
        do_reset(4'b0000);
        req_i = 4'b0100;
        tick();
        tick();
        check("to_start", 32'(mm_start_o), 32'h1);
        tick();
        for (int c = 1; c < 16; c++) begin
            tick();
            check("to_done_early", 32'(done_o), 32'h0);
            check("to_err_early", 32'(err_o), 32'h0);
        end
        tick();
        check("to_done", 32'(done_o), 32'h4);
        check("to_err", 32'(err_o), 32'h1);
        req_i = 4'b0000;
        tick();
        expect_idle("to_end");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
